b2_serial_subtractor: RTL and testbench

//   Parametrised bit-serial base-2 subtractor: computes x - y - bin on N-bit

---
 rtl/b2_serial_subtractor.sv | 134 +++++++++++++
 tb/tb_b2_serial_subtractor.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/b2_serial_subtractor.sv
// b2_serial_subtractor
//   Bit-serial base-2 subtractor computing (x - y - bin) mod 2^N, one bit per
//   clock, LSB first. A single full-subtractor cell is reused every cycle and
//   its borrow is carried in a register from one bit position to the next.
//   Operands enter and the result leaves through valid/ready handshakes.
//
//   Optional build macro: B2_SUB_SAT_EN
//     When defined, a result that underflows (final borrow = 1) is shown as
//     all zeros on d while the block is in DONE. bout still reports 1.
//     When undefined, d is the plain wrap-around difference.

module b2_serial_subtractor #(
  parameter int N = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         bin,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] d,
  output logic         bout,
  output logic         out_valid,
  input  logic         out_ready
);

  // The bit counter needs at least one bit, even for N == 1.
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]    state;
  logic [N-1:0]  x_reg;
  logic [N-1:0]  y_reg;
  logic [N-1:0]  d_reg;
  logic          b_reg;
  logic [CW-1:0] cnt;

  logic          bit_a;
  logic          bit_b;
  logic          bit_c;
  logic          di;
  logic          bo;
  logic [N-1:0]  d_shift;

  // Full-subtractor cell on the current LSBs and the stored borrow.
  always_comb begin
    bit_a = x_reg[0];
    bit_b = y_reg[0];
    bit_c = b_reg;
    di    = bit_a ^ bit_b ^ bit_c;
    bo    = (~bit_a & bit_b) | (~bit_a & bit_c) | (bit_b & bit_c);
  end

  // New difference bit enters at the MSB; after N shifts the first bit
  // computed (the LSB) has reached position 0. A one-bit register has
  // nothing to shift down, so it simply takes the new bit.
  generate
    if (N == 1) begin : g_d_one
      assign d_shift = di;
    end else begin : g_d_wide
      assign d_shift = {di, d_reg[N-1:1]};
    end
  endgenerate

  // Control and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      x_reg <= '0;
      y_reg <= '0;
      d_reg <= '0;
      b_reg <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_reg <= x;
            y_reg <= y;
            b_reg <= bin;
            d_reg <= '0;
            cnt   <= CNT_LAST;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          d_reg <= d_shift;
          x_reg <= x_reg >> 1;
          y_reg <= y_reg >> 1;
          b_reg <= bo;
          cnt   <= cnt - 1'b1;
          if (cnt == '0) begin
            state <= DONE;
          end
        end
        DONE: begin
          // Result is held until the consumer takes it.
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Handshake flags decode directly from the state.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Result outputs; saturation only masks d while the result is presented.
  always_comb begin
    bout = b_reg;
`ifdef B2_SUB_SAT_EN
    if ((state == DONE) && b_reg) begin
      d = '0;
    end else begin
      d = d_reg;
    end
`else
    d = d_reg;
`endif
  end

endmodule

// File: tb/tb_b2_serial_subtractor.sv
// tb_b2_serial_subtractor
//   Directed bench for b2_serial_subtractor: an N=8 instance driven from a
//   table of hand-computed vectors plus hand-written back-pressure and
//   mid-operation reset sequences, and an N=1 instance checked against the
//   full-subtractor truth table. Expected d values follow B2_SUB_SAT_EN.

module tb_b2_serial_subtractor;

  logic       clock = 1'b0;
  logic       reset = 1'b1;

  logic [7:0] x8 = '0;
  logic [7:0] y8 = '0;
  logic       bin8 = 1'b0;
  logic       in_valid8 = 1'b0;
  logic       in_ready8;
  logic [7:0] d8;
  logic       bout8;
  logic       out_valid8;
  logic       out_ready8 = 1'b0;

  logic [0:0] x1 = '0;
  logic [0:0] y1 = '0;
  logic       bin1 = 1'b0;
  logic       in_valid1 = 1'b0;
  logic       in_ready1;
  logic [0:0] d1;
  logic       bout1;
  logic       out_valid1;
  logic       out_ready1 = 1'b0;

  int vec_count  = 0;
  int miss_count = 0;

  always #5 clock = ~clock;

  b2_serial_subtractor #(.N(8)) dut8 (
    .clock     (clock),
    .reset     (reset),
    .x         (x8),
    .y         (y8),
    .bin       (bin8),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .d         (d8),
    .bout      (bout8),
    .out_valid (out_valid8),
    .out_ready (out_ready8)
  );

  b2_serial_subtractor #(.N(1)) dut1 (
    .clock     (clock),
    .reset     (reset),
    .x         (x1),
    .y         (y1),
    .bin       (bin1),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .d         (d1),
    .bout      (bout1),
    .out_valid (out_valid1),
    .out_ready (out_ready1)
  );

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    logic       bin;
    logic [7:0] d;
    logic       bout;
  } vec8_t;

  typedef struct {
    logic x;
    logic y;
    logic bin;
    logic d;
    logic bout;
  } vec1_t;

  vec8_t vecs8[8];
  vec1_t vecs1[8];

  // Expected d as seen in DONE: saturated to zero on underflow when enabled.
  function automatic logic [7:0] shown_d(input logic [7:0] dv, input logic b);
`ifdef B2_SUB_SAT_EN
    return b ? 8'h00 : dv;
`else
    return dv;
`endif
  endfunction

  task automatic check(input string nm, input int tag,
                       input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miss_count++;
      $display("FAIL %s (vec %0d): got %h, expected %h", nm, tag, act, exp);
    end
  endtask

  // Launch one operation on the N=8 instance and wait for out_valid.
  task automatic run8(input logic [7:0] xv, input logic [7:0] yv,
                      input logic bv, input logic [7:0] ed, input logic eb,
                      input int tag);
    int w;
    int cyc;
    w = 0;
    while (!in_ready8 && w < 20) begin
      @(posedge clock); #1;
      w++;
    end
    check("in_ready_before_op", tag, 32'(in_ready8), 32'd1);
    x8 = xv; y8 = yv; bin8 = bv; in_valid8 = 1'b1;
    @(posedge clock); #1;
    in_valid8 = 1'b0;
    x8 = 8'($urandom); y8 = 8'($urandom); bin8 = 1'($urandom);
    check("in_ready_after_accept", tag, 32'(in_ready8), 32'd0);
    cyc = 0;
    while (!out_valid8 && cyc < 40) begin
      @(posedge clock); #1;
      cyc++;
    end
    check("latency8", tag, 32'(cyc), 32'd8);
    check("d8", tag, 32'(d8), 32'(shown_d(ed, eb)));
    check("bout8", tag, 32'(bout8), 32'(eb));
    $display("vec %0d: x=%h y=%h bin=%0d -> d=%h bout=%0d latency=%0d",
             tag, xv, yv, bv, d8, bout8, cyc);
  endtask

  // Consumer takes the result; block must return to IDLE.
  task automatic release8(input int tag);
    out_ready8 = 1'b1;
    @(posedge clock); #1;
    out_ready8 = 1'b0;
    check("in_ready_after_release", tag, 32'(in_ready8), 32'd1);
    check("out_valid_after_release", tag, 32'(out_valid8), 32'd0);
  endtask

  initial begin
    vecs8[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0};
    vecs8[1] = '{8'h10, 8'h20, 1'b0, 8'hF0, 1'b1};
    vecs8[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
    vecs8[3] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0};
    vecs8[4] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0};
    vecs8[5] = '{8'h00, 8'hFF, 1'b0, 8'h01, 1'b1};
    vecs8[6] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0};
    vecs8[7] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};

    vecs1[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs1[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs1[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs1[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs1[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs1[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs1[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs1[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    // Reset state of both instances.
    #3;
    check("rst_in_ready8", 0, 32'(in_ready8), 32'd1);
    check("rst_out_valid8", 0, 32'(out_valid8), 32'd0);
    check("rst_d8", 0, 32'(d8), 32'd0);
    check("rst_bout8", 0, 32'(bout8), 32'd0);
    check("rst_in_ready1", 0, 32'(in_ready1), 32'd1);
    check("rst_out_valid1", 0, 32'(out_valid1), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;

    // Table-driven vectors on the N=8 instance.
    for (int i = 0; i < 8; i++) begin
      run8(vecs8[i].x, vecs8[i].y, vecs8[i].bin, vecs8[i].d, vecs8[i].bout, i);
      release8(i);
    end

    // Back-pressure: hold in DONE for 5 cycles with a stray in_valid pulse.
    run8(8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 100);
    for (int i = 0; i < 5; i++) begin
      in_valid8 = (i == 2);
      x8 = 8'hAA; y8 = 8'h11; bin8 = 1'b1;
      @(posedge clock); #1;
      check("hold_out_valid", 100 + i, 32'(out_valid8), 32'd1);
      check("hold_in_ready", 100 + i, 32'(in_ready8), 32'd0);
      check("hold_d", 100 + i, 32'(d8), 32'(shown_d(8'hF0, 1'b1)));
      check("hold_bout", 100 + i, 32'(bout8), 32'd1);
    end
    in_valid8 = 1'b0;
    release8(105);
    // New operation accepted on the very next cycle.
    run8(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 106);
    release8(106);

    // Reset in the middle of SHIFT aborts the operation.
    x8 = 8'hFF; y8 = 8'h01; bin8 = 1'b0; in_valid8 = 1'b1;
    @(posedge clock); #1;
    in_valid8 = 1'b0;
    repeat (3) begin
      @(posedge clock); #1;
    end
    check("mid_in_ready_pre", 200, 32'(in_ready8), 32'd0);
    reset = 1'b1;
    #1;
    check("abort_out_valid", 200, 32'(out_valid8), 32'd0);
    check("abort_in_ready", 200, 32'(in_ready8), 32'd1);
    check("abort_d", 200, 32'(d8), 32'd0);
    check("abort_bout", 200, 32'(bout8), 32'd0);
    $display("vec 200: reset during SHIFT -> in_ready=%0d out_valid=%0d d=%h bout=%0d",
             in_ready8, out_valid8, d8, bout8);
    @(posedge clock); #1;
    reset = 1'b0;
    check("abort_still_idle", 201, 32'(out_valid8), 32'd0);
    run8(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 202);
    release8(202);

    // N=1 instance: full-subtractor truth table, single SHIFT cycle.
    for (int i = 0; i < 8; i++) begin
      int cyc;
      logic exp_d;
      exp_d = vecs1[i].d;
`ifdef B2_SUB_SAT_EN
      if (vecs1[i].bout) exp_d = 1'b0;
`endif
      check("in_ready1", 300 + i, 32'(in_ready1), 32'd1);
      x1 = vecs1[i].x; y1 = vecs1[i].y; bin1 = vecs1[i].bin; in_valid1 = 1'b1;
      @(posedge clock); #1;
      in_valid1 = 1'b0;
      cyc = 0;
      while (!out_valid1 && cyc < 10) begin
        @(posedge clock); #1;
        cyc++;
      end
      check("latency1", 300 + i, 32'(cyc), 32'd1);
      check("d1", 300 + i, 32'(d1), 32'(exp_d));
      check("bout1", 300 + i, 32'(bout1), 32'(vecs1[i].bout));
      $display("vec %0d: N=1 x=%0d y=%0d bin=%0d -> d=%0d bout=%0d latency=%0d",
               300 + i, vecs1[i].x, vecs1[i].y, vecs1[i].bin, d1, bout1, cyc);
      out_ready1 = 1'b1;
      @(posedge clock); #1;
      out_ready1 = 1'b0;
      check("out_valid1_release", 300 + i, 32'(out_valid1), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
